// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one branch/condition comparator between
// the ID-stage branch unit (req0) and the EX-stage trap unit (req1).
module cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic             rsp_true,
  output logic             rsp_err,
  output logic             last_grant
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LTZ = 3'd2,
    OP_LEZ = 3'd3,
    OP_GTZ = 3'd4,
    OP_GEZ = 3'd5
  } cmp_op_e;

  logic             arb_ok;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             a_neg;
  logic             a_zero;
  logic             a_eq_b;
  logic             cmp_true;
  logic             cmp_err;
  logic             rsp_v;
  logic             rsp_idx;

  // Tie goes to whichever requester did not win last time.
  assign arb_ok = reset & ~flush;
  assign grant0 = arb_ok & req0_valid & (~req1_valid | last_grant);
  assign grant1 = arb_ok & req1_valid & (~req0_valid | ~last_grant);
  assign accept = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  assign a_neg  = sel_a[WIDTH-1];
  assign a_zero = (sel_a == '0);
  assign a_eq_b = (sel_a == sel_b);

  always_comb begin
    cmp_true = 1'b0;
    cmp_err  = 1'b0;
    case (cmp_op_e'(sel_op))
      OP_EQ:   cmp_true = a_eq_b;
      OP_NE:   cmp_true = ~a_eq_b;
      OP_LTZ:  cmp_true = a_neg;
      OP_LEZ:  cmp_true = a_neg | a_zero;
      OP_GTZ:  cmp_true = ~a_neg & ~a_zero;
      OP_GEZ:  cmp_true = ~a_neg;
      default: cmp_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_v      <= 1'b0;
      rsp_idx    <= 1'b0;
      rsp_true   <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_v      <= 1'b1;
      rsp_idx    <= grant1;
      rsp_true   <= cmp_true;
      rsp_err    <= cmp_err;
      last_grant <= grant1;
    end else begin
      rsp_v      <= 1'b0;
    end
  end

  assign rsp0_valid = rsp_v & ~rsp_idx;
  assign rsp1_valid = rsp_v & rsp_idx;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: spec-level model checked every cycle plus
// directed vectors with literal expectations.
module tb_cmp_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [2:0]   req0_op = '0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [2:0]   req1_op = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic         rsp_true;
  logic         rsp_err;
  logic         last_grant;

  int errors = 0;
  int checks = 0;

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_true(rsp_true), .rsp_err(rsp_err),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // Model state: the response owed next cycle and who won last.
  logic exp_v    = 1'b0;
  logic exp_idx  = 1'b0;
  logic exp_true = 1'b0;
  logic exp_err  = 1'b0;
  logic m_last   = 1'b1;

  function automatic logic [1:0] mgrant(input logic rs, input logic fl,
                                        input logic v0, input logic v1,
                                        input logic last);
    if (!rs || fl) return 2'b00;
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  // Returns {err, true}.
  function automatic logic [1:0] meval(input logic [2:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int signed sa;
    sa = $signed(a);
    case (op)
      3'd0: return {1'b0, a == b};
      3'd1: return {1'b0, a != b};
      3'd2: return {1'b0, sa < 0};
      3'd3: return {1'b0, sa <= 0};
      3'd4: return {1'b0, sa > 0};
      3'd5: return {1'b0, sa >= 0};
      default: return 2'b10;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [1:0] g;
    logic [1:0] r;
    if (!reset) begin
      exp_v  <= 1'b0;
      m_last <= 1'b1;
    end else begin
      g = mgrant(reset, flush, req0_valid, req1_valid, m_last);
      if (g != 2'b00) begin
        r = g[1] ? meval(req1_op, req1_a, req1_b)
                 : meval(req0_op, req0_a, req0_b);
        exp_v    <= 1'b1;
        exp_idx  <= g[1];
        exp_err  <= r[1];
        exp_true <= r[0];
        m_last   <= g[1];
      end else begin
        exp_v <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] g;
    g = mgrant(reset, flush, req0_valid, req1_valid, m_last);
    chk("m_ready0", req0_ready, g[0]);
    chk("m_ready1", req1_ready, g[1]);
    chk("m_rsp0", rsp0_valid, exp_v && !exp_idx);
    chk("m_rsp1", rsp1_valid, exp_v && exp_idx);
    chk("m_last_grant", last_grant, m_last);
    if (exp_v) begin
      chk("m_rsp_true", rsp_true, exp_true);
      chk("m_rsp_err", rsp_err, exp_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  logic [3:0] sgn_tbl [3];
  logic [W-1:0] sgn_a [3];

  initial begin
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sgn_a   = '{32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    sgn_tbl = '{4'b1100, 4'b0101, 4'b0011};

    // Reset held: readys forced low even with valids up.
    repeat (3) begin
      look();
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      chk("rst_last", last_grant, 1'b1);
      chk("rst_rsp0", rsp0_valid, 1'b0);
      chk("rst_err", rsp_err, 1'b0);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      look();
      chk("idle_ready0", req0_ready, 1'b0);
      chk("idle_ready1", req1_ready, 1'b0);
    end

    // Single requester EQ, true then false.
    for (int k = 0; k < 2; k++) begin
      step();
      req0_valid = 1'b1;
      req0_op = 3'd0;
      req0_a = 32'h1234;
      req0_b = (k == 0) ? 32'h1234 : 32'h1235;
      look();
      chk("eq_ready0", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      look();
      chk("eq_rsp0", rsp0_valid, 1'b1);
      chk("eq_true", rsp_true, (k == 0));
      step();
      look();
      chk("eq_pulse_end", rsp0_valid, 1'b0);
    end

    // Fresh reset, then a 4-cycle tie.
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op = 3'd1;
    req1_op = 3'd5;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("rr_ready0", req0_ready, (i % 2) == 0);
      chk("rr_ready1", req1_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("rr_rsp0", rsp0_valid, (i % 2) == 1);
        chk("rr_rsp1", rsp1_valid, (i % 2) == 0);
        chk("rr_last", last_grant, (i % 2) == 0);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Signed tests on requester 1.
    for (int j = 0; j < 3; j++) begin
      for (int op = 2; op <= 5; op++) begin
        req1_valid = 1'b1;
        req1_op = 3'(op);
        req1_a = sgn_a[j];
        req1_b = 32'h5555_AAAA;
        step();
        req1_valid = 1'b0;
        look();
        chk("sgn_rsp1", rsp1_valid, 1'b1);
        chk("sgn_true", rsp_true, sgn_tbl[j][5 - op]);
        step();
      end
    end

    // Flush kills the next accept but not the visible response.
    req0_valid = 1'b1;
    req0_op = 3'd0;
    req0_a = 32'd7;
    req0_b = 32'd7;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_op = 3'd1;
    req1_a = 32'd1;
    req1_b = 32'd2;
    flush = 1'b1;
    look();
    chk("fl_rsp0", rsp0_valid, 1'b1);
    chk("fl_ready1", req1_ready, 1'b0);
    step();
    flush = 1'b0;
    look();
    chk("fl_no_rsp0", rsp0_valid, 1'b0);
    chk("fl_no_rsp1", rsp1_valid, 1'b0);
    chk("fl_ready1_back", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    look();
    chk("fl_rsp1", rsp1_valid, 1'b1);
    chk("fl_true", rsp_true, 1'b1);
    step();

    // Reserved op.
    req0_valid = 1'b1;
    req0_op = 3'd7;
    req0_a = 32'd3;
    req0_b = 32'd3;
    step();
    req0_valid = 1'b0;
    look();
    chk("rsv_err", rsp_err, 1'b1);
    chk("rsv_true", rsp_true, 1'b0);
    step();

    // Reset lands right after the accept edge: response is lost.
    req0_valid = 1'b1;
    req0_op = 3'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_valid = 1'b0;
    look();
    chk("mid_rsp0", rsp0_valid, 1'b0);
    chk("mid_last", last_grant, 1'b1);
    step();
    reset = 1'b1;
    repeat (2) begin
      look();
      chk("post_rsp0", rsp0_valid, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
